// File: rtl/mode_sequencer_if.sv
// Key-request / mode-select bundle between the keypad front end and the mode sequencer.
interface mode_sequencer_if #(
   parameter int NUM_MODES = 3
);
   localparam int IDX_W = $clog2(NUM_MODES);

   logic                 next_req;
   logic                 prev_req;
   logic                 activity;
   logic [IDX_W-1:0]     mode_idx;
   logic [NUM_MODES-1:0] mode_onehot;
   logic                 mode_changed;
   logic                 timeout_pulse;

   modport master (
      output next_req, prev_req, activity,
      input  mode_idx, mode_onehot, mode_changed, timeout_pulse
   );

   modport slave (
      input  next_req, prev_req, activity,
      output mode_idx, mode_onehot, mode_changed, timeout_pulse
   );
endinterface

// File: rtl/mode_sequencer.sv
// Alarm-clock mode sequencer: edge-detected forward/backward stepping with wrap and change strobe.
// Optional inactivity return to HOME_MODE is compiled in when MODE_SEQ_TIMEOUT_EN is defined.
module mode_sequencer #(
   parameter int NUM_MODES      = 3,
   parameter int HOME_MODE      = 0,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic             clock,
   input  logic             reset,
   mode_sequencer_if.slave  bus
);
   localparam int                   IDX_W      = $clog2(NUM_MODES);
   localparam logic [IDX_W-1:0]     HOME_IDX   = IDX_W'(HOME_MODE);
   localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_MODES - 1);
   // One extra bit keeps the range check meaningful when NUM_MODES is a power of two.
   localparam logic [IDX_W:0]       MODE_LIMIT = (IDX_W + 1)'(NUM_MODES);
   localparam logic [NUM_MODES-1:0] HOME_OH    = {{(NUM_MODES - 1){1'b0}}, 1'b1} << HOME_MODE;

   logic                 next_q;
   logic                 prev_q;
   logic [IDX_W-1:0]     mode_idx_q;
   logic [IDX_W-1:0]     mode_idx_d;
   logic [IDX_W-1:0]     mode_last_q;
   logic [NUM_MODES-1:0] mode_onehot_q;
   logic [NUM_MODES-1:0] mode_onehot_d;
   logic                 mode_changed_q;
   logic                 nxt_s;
   logic                 prv_s;
   logic [IDX_W-1:0]     mode_inc_s;
   logic [IDX_W-1:0]     mode_dec_s;
   logic                 timeout_s;

   // Request edge detection and wrapped neighbour modes.
   always_comb begin
      nxt_s = bus.next_req & ~next_q;
      prv_s = bus.prev_req & ~prev_q;
      if (mode_idx_q == LAST_IDX) begin
         mode_inc_s = {IDX_W{1'b0}};
      end else begin
         mode_inc_s = mode_idx_q + IDX_W'(1);
      end
      if (mode_idx_q == {IDX_W{1'b0}}) begin
         mode_dec_s = LAST_IDX;
      end else begin
         mode_dec_s = mode_idx_q - IDX_W'(1);
      end
   end

   // Next mode selection in priority order, plus its one-hot image.
   always_comb begin
      mode_idx_d = mode_idx_q;
      if ({1'b0, mode_idx_q} >= MODE_LIMIT) begin
         mode_idx_d = HOME_IDX;
      end else if (nxt_s & prv_s) begin
         mode_idx_d = mode_idx_q;
      end else if (nxt_s) begin
         mode_idx_d = mode_inc_s;
      end else if (prv_s) begin
         mode_idx_d = mode_dec_s;
      end else if (timeout_s) begin
         mode_idx_d = HOME_IDX;
      end else begin
         mode_idx_d = mode_idx_q;
      end
      mode_onehot_d = {NUM_MODES{1'b0}};
      for (int i = 0; i < NUM_MODES; i++) begin
         mode_onehot_d[i] = (mode_idx_d == IDX_W'(i));
      end
   end

   // Mode state, edge-detect history and the change strobe (one cycle behind the mode update).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         next_q         <= 1'b0;
         prev_q         <= 1'b0;
         mode_idx_q     <= HOME_IDX;
         mode_last_q    <= HOME_IDX;
         mode_onehot_q  <= HOME_OH;
         mode_changed_q <= 1'b0;
      end else begin
         next_q         <= bus.next_req;
         prev_q         <= bus.prev_req;
         mode_idx_q     <= mode_idx_d;
         mode_last_q    <= mode_idx_q;
         mode_onehot_q  <= mode_onehot_d;
         mode_changed_q <= (mode_idx_q != mode_last_q);
      end
   end

   assign bus.mode_idx     = mode_idx_q;
   assign bus.mode_onehot  = mode_onehot_q;
   assign bus.mode_changed = mode_changed_q;

`ifdef MODE_SEQ_TIMEOUT_EN
   localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic          timeout_pend_q;
   logic          timeout_pulse_q;
   logic          event_s;

   // Idle timer: restarts on any user event or while at home, fires instead of reaching the limit.
   always_comb begin
      event_s   = nxt_s | prv_s | bus.activity;
      timeout_s = 1'b0;
      timer_d   = timer_q;
      if ((mode_idx_q == HOME_IDX) || event_s) begin
         timer_d = {TW{1'b0}};
      end else if (timer_q == TIMER_LAST) begin
         timer_d   = {TW{1'b0}};
         timeout_s = 1'b1;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Timer state; the pulse is delayed one stage so it lines up with mode_changed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_q         <= {TW{1'b0}};
         timeout_pend_q  <= 1'b0;
         timeout_pulse_q <= 1'b0;
      end else begin
         timer_q         <= timer_d;
         timeout_pend_q  <= timeout_s;
         timeout_pulse_q <= timeout_pend_q;
      end
   end

   assign bus.timeout_pulse = timeout_pulse_q;
`else
   logic unused_s;

   assign timeout_s         = 1'b0;
   assign bus.timeout_pulse = 1'b0;
   assign unused_s          = bus.activity ^ (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: vector table for stepping/wrap, hand sequences for hold, timeout and reset.
module tb_mode_sequencer;
   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   mode_sequencer_if #(.NUM_MODES(3)) bus3 ();
   mode_sequencer_if #(.NUM_MODES(5)) bus5 ();

   mode_sequencer #(.NUM_MODES(3), .HOME_MODE(0), .TIMEOUT_CYCLES(8)) dut3 (
      .clock(clock), .reset(reset), .bus(bus3));
   mode_sequencer #(.NUM_MODES(5), .HOME_MODE(0), .TIMEOUT_CYCLES(1000)) dut5 (
      .clock(clock), .reset(reset), .bus(bus5));

   typedef struct {
      logic nr;
      logic pr;
      int   exp_idx;
      logic exp_ch;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check3(input string tag, input int idx, input logic ch, input logic tp);
      logic [2:0] oh;
      oh = 3'b001 << idx;
      chk({tag, ".idx"}, 32'(bus3.mode_idx), 32'(idx));
      chk({tag, ".onehot"}, 32'(bus3.mode_onehot), 32'(oh));
      chk({tag, ".changed"}, 32'(bus3.mode_changed), 32'(ch));
      chk({tag, ".timeout"}, 32'(bus3.timeout_pulse), 32'(tp));
   endtask

   task automatic mid_cycle_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      check3(tag, 0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      tick();
      check3({tag, ".after"}, 0, 1'b0, 1'b0);
   endtask

   task automatic prev_pulse3();
      bus3.prev_req = 1'b1;
      tick();
      bus3.prev_req = 1'b0;
   endtask

   initial begin
      int pulses;
      logic tp_seen;

      vecs[0]  = '{1'b1, 1'b0, 1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 2, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 2, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 0, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 2, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 2, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 0, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 0, 1'b1};
      vecs[16] = '{1'b0, 1'b1, 0, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 0, 1'b0};

      reset = 1'b1;
      bus3.next_req = 1'b0; bus3.prev_req = 1'b0; bus3.activity = 1'b0;
      bus5.next_req = 1'b0; bus5.prev_req = 1'b0; bus5.activity = 1'b0;
      #12;
      check3("reset", 0, 1'b0, 1'b0);
      chk("reset5.onehot", 32'(bus5.mode_onehot), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      tick();
      check3("release", 0, 1'b0, 1'b0);

      for (int i = 0; i < 18; i++) begin
         bus3.next_req = vecs[i].nr;
         bus3.prev_req = vecs[i].pr;
         tick();
         check3($sformatf("vec%0d", i), vecs[i].exp_idx, vecs[i].exp_ch, 1'b0);
      end

      // Holding next_req advances exactly one step.
      prev_pulse3();
      tick();
      check3("hold.pre", 2, 1'b1, 1'b0);
      bus3.next_req = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus3.mode_changed === 1'b1) pulses++;
         chk($sformatf("hold.idx%0d", k), 32'(bus3.mode_idx), 32'd0);
      end
      chk("hold.pulses", 32'(pulses), 32'd1);
      bus3.next_req = 1'b0;
      tick();
      check3("hold.post", 0, 1'b0, 1'b0);

`ifdef MODE_SEQ_TIMEOUT_EN
      // Idle return after exactly 8 cycles, then reset while the pulse is high.
      prev_pulse3();
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("to.wait%0d", k), 32'(bus3.mode_idx), 32'd2);
      end
      tick();
      check3("to.return", 0, 1'b0, 1'b0);
      tick();
      check3("to.pulse", 0, 1'b1, 1'b1);
      mid_cycle_reset("to.rst");

      // Activity at cycle 6 delays the return to 8 cycles after it.
      prev_pulse3();
      for (int k = 1; k < 6; k++) tick();
      bus3.activity = 1'b1;
      tick();
      bus3.activity = 1'b0;
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("act.wait%0d", k), 32'(bus3.mode_idx), 32'd2);
      end
      tick();
      check3("act.return", 0, 1'b0, 1'b0);
      tick();
      check3("act.pulse", 0, 1'b1, 1'b1);
      tick();
      check3("act.quiet", 0, 1'b0, 1'b0);

      // Simultaneous edges restart the timer without changing mode.
      bus3.next_req = 1'b1;
      tick();
      bus3.next_req = 1'b0;
      tick(); tick(); tick();
      bus3.next_req = 1'b1;
      bus3.prev_req = 1'b1;
      tick();
      bus3.next_req = 1'b0;
      bus3.prev_req = 1'b0;
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("sim.wait%0d", k), 32'(bus3.mode_idx), 32'd1);
      end
      tick();
      check3("sim.return", 0, 1'b0, 1'b0);
      tick();
      check3("sim.pulse", 0, 1'b1, 1'b1);
`else
      // Without the timer, an idle non-home mode is held indefinitely.
      prev_pulse3();
      tp_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         bus3.activity = k[0];
         tick();
         if (bus3.timeout_pulse !== 1'b0) tp_seen = 1'b1;
      end
      bus3.activity = 1'b0;
      chk("idle.idx", 32'(bus3.mode_idx), 32'd2);
      chk("idle.timeout", 32'(tp_seen), 32'd0);
      bus3.next_req = 1'b1;
      tick();
      bus3.next_req = 1'b0;
      tick();
      check3("idle.back", 0, 1'b1, 1'b0);
`endif

      // Asynchronous reset while mode_changed is high.
      prev_pulse3();
      tick();
      check3("rst1.pre", 2, 1'b1, 1'b0);
      mid_cycle_reset("rst1");

      // Asynchronous reset in mode 2 with the timer at 5.
      prev_pulse3();
      for (int k = 0; k < 5; k++) tick();
      check3("rst2.pre", 2, 1'b0, 1'b0);
      mid_cycle_reset("rst2");

      // Non-power-of-two wrap on the five-mode instance.
      for (int s = 1; s <= 5; s++) begin
         logic [4:0] oh5;
         bus5.next_req = 1'b1;
         tick();
         oh5 = 5'b00001 << (s % 5);
         chk($sformatf("m5.idx%0d", s), 32'(bus5.mode_idx), 32'(s % 5));
         chk($sformatf("m5.oh%0d", s), 32'(bus5.mode_onehot), 32'(oh5));
         bus5.next_req = 1'b0;
         tick();
         chk($sformatf("m5.range%0d", s), 32'(bus5.mode_idx < 3'd5), 32'd1);
         chk($sformatf("m5.ch%0d", s), 32'(bus5.mode_changed), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
